spu_boot_loader: RTL and testbench

SPU_BOOT_LOADER -- requirements
Module: spu_boot_loader

---
 rtl/spu_boot_loader_pkg.sv | 37 +++
 rtl/spu_load_counter.sv | 39 +++
 rtl/spu_boot_loader.sv | 219 +++++++++++++++++++++
 tb/tb_spu_boot_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_boot_loader_pkg.sv
// Shared definitions for the SPU boot loader.
//   target_e : two-bit header target field
//   state_e  : loader FSM states
//   HDR_*    : header field offsets. in_data uses an MSB-first index, so bit 0
//              is the most significant bit of the stream word.
package spu_boot_loader_pkg;

  typedef enum logic [1:0] {
    TGT_IMEM = 2'b00,
    TGT_RF   = 2'b01,
    TGT_LS   = 2'b10,
    TGT_END  = 2'b11
  } target_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_IMEM,
    ST_RF,
    ST_LS,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int HDR_TGT_POS  = 0;
  localparam int HDR_TGT_W    = 2;
  localparam int HDR_ADDR_POS = 2;
  localparam int HDR_ADDR_W   = 16;
  localparam int HDR_CNT_POS  = 18;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spu_load_counter.sv
// Address / remaining-count register pair for one payload block.
//   load_i      : capture a new start address and word count
//   step_i      : one word written; advance address, consume one count
//   addr_o      : current write address
//   last_o      : the word being accepted now is the final one of the block
module spu_load_counter #(
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [CNT_W-1:0]  load_cnt_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  rem_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (load_i) begin
      addr_q <= load_addr_i;
      rem_q  <= load_cnt_i;
    end else if (step_i) begin
      addr_q <= addr_q + 1'b1;
      rem_q  <= rem_q - 1'b1;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (rem_q == CNT_W'(1));

endmodule

// File: rtl/spu_boot_loader.sv
// SPU boot loader: parses a header/payload word stream and writes the
// instruction memory, register file or local store while the core is held
// in reset.
//   start/busy/done/err : session control and status
//   in_valid/in_ready/in_data : stream input (in_data bit 0 = MSB)
//   load_en/instruction_in/instr_load_addr     : instruction memory write
//   preload_en/preload_addr/preload_values     : register file write
//   preload_LS_en/preload_LS_addr/preload_LS_data : local store write
//   core_rst : core reset, released one cycle after a clean END
//
// state | meaning
// IDLE  | after reset, waiting for start
// HDR   | expecting a header word
// IMEM  | payload words go to instruction memory
// RF    | payload words go to the register file
// LS    | payload words go to local store
// DONE  | END header seen, core released
// ERR   | header ran past the top of its target, core kept in reset
module spu_boot_loader
  import spu_boot_loader_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int INSTR_W = 32,
  parameter int IMEM_AW = 10,
  parameter int RF_AW   = 7,
  parameter int LS_AW   = 15,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:DATA_W-1]  in_data,
  output logic               load_en,
  output logic [INSTR_W-1:0] instruction_in,
  output logic [IMEM_AW-1:0] instr_load_addr,
  output logic               preload_en,
  output logic [RF_AW-1:0]   preload_addr,
  output logic [DATA_W-1:0]  preload_values,
  output logic               preload_LS_en,
  output logic [LS_AW-1:0]   preload_LS_addr,
  output logic [DATA_W-1:0]  preload_LS_data,
  output logic               core_rst,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CTR_AW = max3(IMEM_AW, RF_AW, LS_AW);

  state_e state_q, state_d;
  logic   core_rst_q, core_rst_d;

  logic               load_en_q;
  logic [INSTR_W-1:0] instr_q;
  logic [IMEM_AW-1:0] imem_addr_q;
  logic               rf_en_q;
  logic [RF_AW-1:0]   rf_addr_q;
  logic [DATA_W-1:0]  rf_data_q;
  logic               ls_en_q;
  logic [LS_AW-1:0]   ls_addr_q;
  logic [DATA_W-1:0]  ls_data_q;

  logic              accept;
  target_e           hdr_tgt;
  logic [CTR_AW-1:0] hdr_addr_low;
  logic [CNT_W-1:0]  hdr_cnt;
  int                tgt_aw;
  logic [CTR_AW-1:0] addr_mask;
  logic [CTR_AW-1:0] hdr_start;
  logic [31:0]       hdr_end;
  logic [31:0]       hdr_limit;
  logic              hdr_overflow;

  logic              ctr_load;
  logic              ctr_step;
  logic [CTR_AW-1:0] ctr_addr;
  logic              ctr_last;

  assign in_ready = (state_q == ST_HDR) || (state_q == ST_IMEM) ||
                    (state_q == ST_RF)  || (state_q == ST_LS);
  assign accept   = in_valid && in_ready;

  // Only the low CTR_AW bits of the 16-bit address field can ever matter;
  // the target mask below trims them further.
  assign hdr_tgt      = target_e'(in_data[HDR_TGT_POS +: HDR_TGT_W]);
  assign hdr_addr_low = in_data[HDR_ADDR_POS + HDR_ADDR_W - CTR_AW +: CTR_AW];
  assign hdr_cnt      = in_data[HDR_CNT_POS +: CNT_W];

  always_comb begin
    tgt_aw = LS_AW;
    case (hdr_tgt)
      TGT_IMEM: tgt_aw = IMEM_AW;
      TGT_RF:   tgt_aw = RF_AW;
      default:  tgt_aw = LS_AW;
    endcase
  end

  // Compared in 32 bits so start+count cannot wrap; ending exactly at
  // 2^AW is a legal load that fills up to the top address.
  assign addr_mask    = CTR_AW'((32'd1 << tgt_aw) - 32'd1);
  assign hdr_start    = hdr_addr_low & addr_mask;
  assign hdr_end      = 32'(hdr_start) + 32'(hdr_cnt);
  assign hdr_limit    = 32'd1 << tgt_aw;
  assign hdr_overflow = (hdr_end > hdr_limit);

  always_comb begin
    state_d    = state_q;
    core_rst_d = core_rst_q;
    ctr_load   = 1'b0;
    ctr_step   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (state_q == ST_DONE) core_rst_d = 1'b0;
        if (start) begin
          state_d    = ST_HDR;
          core_rst_d = 1'b1;
        end
      end
      ST_HDR: begin
        if (accept) begin
          if (hdr_tgt == TGT_END) begin
            state_d = ST_DONE;
          end else if (hdr_cnt == '0) begin
            state_d = ST_HDR;
          end else if (hdr_overflow) begin
            state_d = ST_ERR;
          end else begin
            ctr_load = 1'b1;
            case (hdr_tgt)
              TGT_IMEM: state_d = ST_IMEM;
              TGT_RF:   state_d = ST_RF;
              default:  state_d = ST_LS;
            endcase
          end
        end
      end
      ST_IMEM, ST_RF, ST_LS: begin
        if (accept) begin
          ctr_step = 1'b1;
          if (ctr_last) state_d = ST_HDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      core_rst_q  <= 1'b1;
      load_en_q   <= 1'b0;
      instr_q     <= '0;
      imem_addr_q <= '0;
      rf_en_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      ls_en_q     <= 1'b0;
      ls_addr_q   <= '0;
      ls_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= core_rst_d;
      load_en_q  <= 1'b0;
      rf_en_q    <= 1'b0;
      ls_en_q    <= 1'b0;
      if (accept) begin
        case (state_q)
          ST_IMEM: begin
            load_en_q   <= 1'b1;
            instr_q     <= in_data[0 +: INSTR_W];
            imem_addr_q <= ctr_addr[IMEM_AW-1:0];
          end
          ST_RF: begin
            rf_en_q   <= 1'b1;
            rf_addr_q <= ctr_addr[RF_AW-1:0];
            rf_data_q <= in_data;
          end
          ST_LS: begin
            ls_en_q   <= 1'b1;
            ls_addr_q <= ctr_addr[LS_AW-1:0];
            ls_data_q <= in_data;
          end
          default: ;
        endcase
      end
    end
  end

  spu_load_counter #(
    .ADDR_W (CTR_AW),
    .CNT_W  (CNT_W)
  ) u_cnt (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (ctr_load),
    .load_addr_i (hdr_start),
    .load_cnt_i  (hdr_cnt),
    .step_i      (ctr_step),
    .addr_o      (ctr_addr),
    .last_o      (ctr_last)
  );

  assign load_en         = load_en_q;
  assign instruction_in  = instr_q;
  assign instr_load_addr = imem_addr_q;
  assign preload_en      = rf_en_q;
  assign preload_addr    = rf_addr_q;
  assign preload_values  = rf_data_q;
  assign preload_LS_en   = ls_en_q;
  assign preload_LS_addr = ls_addr_q;
  assign preload_LS_data = ls_data_q;
  assign core_rst        = core_rst_q;
  assign busy            = in_ready;
  assign done            = (state_q == ST_DONE);
  assign err             = (state_q == ST_ERR);

endmodule

// File: tb/tb_spu_boot_loader.sv
// Directed bench for spu_boot_loader: every write strobe is logged at the
// falling edge and compared against hand-computed address/data sequences.
module tb_spu_boot_loader;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           in_valid;
  logic           in_ready;
  logic [0:127]   in_data;
  logic           load_en;
  logic [31:0]    instruction_in;
  logic [9:0]     instr_load_addr;
  logic           preload_en;
  logic [6:0]     preload_addr;
  logic [127:0]   preload_values;
  logic           preload_LS_en;
  logic [14:0]    preload_LS_addr;
  logic [127:0]   preload_LS_data;
  logic           core_rst;
  logic           busy;
  logic           done;
  logic           err;

  int n_checks = 0;
  int n_err    = 0;

  localparam int K_IMEM = 0;
  localparam int K_RF   = 1;
  localparam int K_LS   = 2;

  typedef struct {
    int           kind;
    int           addr;
    logic [127:0] data;
  } wr_t;

  wr_t log_q[$];

  spu_boot_loader dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .load_en         (load_en),
    .instruction_in  (instruction_in),
    .instr_load_addr (instr_load_addr),
    .preload_en      (preload_en),
    .preload_addr    (preload_addr),
    .preload_values  (preload_values),
    .preload_LS_en   (preload_LS_en),
    .preload_LS_addr (preload_LS_addr),
    .preload_LS_data (preload_LS_data),
    .core_rst        (core_rst),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check_eq("onehot_strobe", 128'(32'(load_en) + 32'(preload_en) + 32'(preload_LS_en) <= 1), 128'd1);
      if (load_en)       log_q.push_back('{K_IMEM, int'(instr_load_addr), 128'(instruction_in)});
      if (preload_en)    log_q.push_back('{K_RF,   int'(preload_addr),    preload_values});
      if (preload_LS_en) log_q.push_back('{K_LS,   int'(preload_LS_addr), preload_LS_data});
    end
  end

  function automatic logic [127:0] hdr(input logic [1:0] t, input logic [15:0] a, input logic [15:0] c);
    return {t, a, c, 94'd0};
  endfunction

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [127:0] w);
    int n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("send_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_wr(input string tag, input int idx, input int kind, input int addr, input logic [127:0] data);
    if (idx < log_q.size()) begin
      check_eq({tag, "_kind"}, 128'(log_q[idx].kind), 128'(kind));
      check_eq({tag, "_addr"}, 128'(log_q[idx].addr), 128'(addr));
      check_eq({tag, "_data"}, log_q[idx].data, data);
    end else begin
      check_eq({tag, "_missing"}, 128'(log_q.size()), 128'(idx + 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  localparam bit [6:0] LS_PAT = 7'b1001101;

  initial begin
    int k;
    logic p;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 128'(in_ready), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_done", 128'(done), 128'd0);
    check_eq("rst_err", 128'(err), 128'd0);
    check_eq("rst_core_rst", 128'(core_rst), 128'd1);
    check_eq("rst_strobes", 128'({load_en, preload_en, preload_LS_en}), 128'd0);
    check_eq("rst_addr", 128'({instr_load_addr, preload_addr, preload_LS_addr}), 128'd0);
    rst = 1'b0;
    idle(2);
    check_eq("idle_ready", 128'(in_ready), 128'd0);

    // IMEM load of three words, then END
    pulse_start();
    check_eq("s1_busy", 128'(busy), 128'd1);
    check_eq("s1_core_rst", 128'(core_rst), 128'd1);
    log_q.delete();
    send(hdr(2'b00, 16'd0, 16'd3));
    send(rep(8'h11));
    send(rep(8'h22));
    send(rep(8'h33));
    send(hdr(2'b11, 16'd0, 16'd0));
    check_eq("s1_done", 128'(done), 128'd1);
    check_eq("s1_busy_done", 128'(busy), 128'd0);
    check_eq("s1_core_rst_entry", 128'(core_rst), 128'd1);
    idle(1);
    check_eq("s1_core_rst_rel", 128'(core_rst), 128'd0);
    check_eq("s1_nwr", 128'(log_q.size()), 128'd3);
    check_wr("s1_w0", 0, K_IMEM, 0, 128'h11111111);
    check_wr("s1_w1", 1, K_IMEM, 1, 128'h22222222);
    check_wr("s1_w2", 2, K_IMEM, 2, 128'h33333333);

    // RF load ending exactly at the top, then one past the top
    pulse_start();
    check_eq("s2_done_clr", 128'(done), 128'd0);
    check_eq("s2_core_rst", 128'(core_rst), 128'd1);
    log_q.delete();
    send(hdr(2'b01, 16'd126, 16'd2));
    send(rep(8'h5A));
    send(rep(8'hA5));
    idle(1);
    check_eq("s2_nwr", 128'(log_q.size()), 128'd2);
    check_wr("s2_w0", 0, K_RF, 126, rep(8'h5A));
    check_wr("s2_w1", 1, K_RF, 127, rep(8'hA5));
    check_eq("s2_no_err", 128'(err), 128'd0);
    log_q.delete();
    send(hdr(2'b01, 16'd127, 16'd2));
    check_eq("s2_err", 128'(err), 128'd1);
    check_eq("s2_err_busy", 128'(busy), 128'd0);
    idle(2);
    check_eq("s2_err_core_rst", 128'(core_rst), 128'd1);
    check_eq("s2_err_nwr", 128'(log_q.size()), 128'd0);

    // LS load with in_valid stalls
    pulse_start();
    check_eq("s3_err_clr", 128'(err), 128'd0);
    log_q.delete();
    send(hdr(2'b10, 16'h7FF0, 16'd4));
    k = 0;
    for (int i = 6; i >= 0; i--) begin
      p = LS_PAT[i];
      in_valid = p;
      in_data  = rep(8'(8'hA0 + k));
      @(posedge clk);
      #1;
      check_eq("s3_ls_stb", 128'(preload_LS_en), 128'(p));
      if (p) k++;
    end
    in_valid = 1'b0;
    idle(1);
    check_eq("s3_nwr", 128'(log_q.size()), 128'd4);
    for (int i = 0; i < 4; i++)
      check_wr("s3_w", i, K_LS, 'h7FF0 + i, rep(8'(8'hA0 + i)));
    check_eq("s3_back_hdr", 128'(in_ready), 128'd1);

    // zero-count header, then a single IMEM word
    log_q.delete();
    send(hdr(2'b00, 16'd5, 16'd0));
    idle(1);
    check_eq("s4_zero_nwr", 128'(log_q.size()), 128'd0);
    check_eq("s4_zero_hdr", 128'(in_ready), 128'd1);
    send(hdr(2'b00, 16'd9, 16'd1));
    send(rep(8'h55));
    idle(1);
    check_eq("s4_nwr", 128'(log_q.size()), 128'd1);
    check_wr("s4_w0", 0, K_IMEM, 9, 128'h55555555);
    send(hdr(2'b11, 16'd0, 16'd0));
    check_eq("s4_done", 128'(done), 128'd1);

    // reset after the second of five words
    pulse_start();
    log_q.delete();
    send(hdr(2'b00, 16'h10, 16'd5));
    send(rep(8'h61));
    send(rep(8'h62));
    idle(1);
    check_eq("s5_pre_nwr", 128'(log_q.size()), 128'd2);
    check_wr("s5_w1", 1, K_IMEM, 'h11, 128'h62626262);
    rst = 1'b1;
    #1;
    check_eq("s5_rst_core", 128'(core_rst), 128'd1);
    check_eq("s5_rst_busy", 128'(busy), 128'd0);
    check_eq("s5_rst_ready", 128'(in_ready), 128'd0);
    in_valid = 1'b1;
    in_data  = rep(8'h63);
    idle(2);
    rst = 1'b0;
    idle(3);
    check_eq("s5_idle_busy", 128'(busy), 128'd0);
    check_eq("s5_idle_done", 128'(done), 128'd0);
    in_valid = 1'b0;
    check_eq("s5_post_nwr", 128'(log_q.size()), 128'd2);
    log_q.delete();
    pulse_start();
    send(hdr(2'b00, 16'h20, 16'd2));
    send(rep(8'h71));
    send(rep(8'h72));
    send(hdr(2'b11, 16'd0, 16'd0));
    check_eq("s5_nwr", 128'(log_q.size()), 128'd2);
    check_wr("s5_n0", 0, K_IMEM, 'h20, 128'h71717171);
    check_wr("s5_n1", 1, K_IMEM, 'h21, 128'h72727272);
    check_eq("s5_done", 128'(done), 128'd1);

    // start pulsed during an RF payload has no effect
    pulse_start();
    log_q.delete();
    send(hdr(2'b01, 16'h40, 16'd3));
    send(rep(8'h81));
    pulse_start();
    send(rep(8'h82));
    send(rep(8'h83));
    idle(1);
    check_eq("s6_nwr", 128'(log_q.size()), 128'd3);
    check_wr("s6_w0", 0, K_RF, 'h40, rep(8'h81));
    check_wr("s6_w1", 1, K_RF, 'h41, rep(8'h82));
    check_wr("s6_w2", 2, K_RF, 'h42, rep(8'h83));
    check_eq("s6_busy", 128'(busy), 128'd1);
    send(hdr(2'b11, 16'd0, 16'd0));
    idle(1);
    check_eq("s6_done", 128'(done), 128'd1);
    check_eq("s6_core_rst", 128'(core_rst), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
